uart_rx_frame_loader: RTL and testbench

- UART 8N1 receiver plus image-frame assembler. Feeds the 512-byte RX FIFO RAM that backs instruction-memory reinitialisation.
- Deserialises the rx pin and writes each good byte to the next FIFO address.
- Raises rx_fifo_full once DEPTH bytes have landed, then holds it until the downstream copy engine returns rx_fifo_full_ack. The copy engine holds the CPU in reset while full is high.

---
 rtl/uart_rx_frame_loader.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_frame_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_loader.sv
// rtl/uart_rx_frame_loader.sv - UART 8N1 receiver that fills a DEPTH-byte RX FIFO frame
// and holds rx_fifo_full until the copy engine acknowledges the frame.
module uart_rx_frame_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int DEPTH        = 512,
   parameter int ADDR_W       = 9,
   parameter int TIMEOUT_CLKS = 1200000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx,
   input  logic              rx_fifo_full_ack,
   output logic [7:0]        rx_fifo_wd,
   output logic [ADDR_W-1:0] rx_fifo_wa,
   output logic              rx_fifo_wen,
   output logic              rx_fifo_full,
   output logic              framing_err,
   output logic              overrun
);

   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam int TMO_W = $clog2(TIMEOUT_CLKS);

   localparam logic [TMR_W-1:0]  HALF_LD  = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0]  BIT_LD   = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state, state_nx;
   logic              rx_meta, rs, rs_d;
   logic [TMR_W-1:0]  tmr, tmr_nx;
   logic [2:0]        idx, idx_nx;
   logic [7:0]        sh, sh_nx;
   logic              tick;
   logic              byte_good, byte_bad;
   logic [ADDR_W-1:0] count;
   logic [TMO_W-1:0]  tmo;
   logic              full_pend;

   assign tick = (tmr == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rs      <= 1'b1;
         rs_d    <= 1'b1;
         state   <= IDLE;
         tmr     <= '0;
         idx     <= '0;
         sh      <= '0;
      end else begin
         rx_meta <= rx;
         rs      <= rx_meta;
         rs_d    <= rs;
         state   <= state_nx;
         tmr     <= tmr_nx;
         idx     <= idx_nx;
         sh      <= sh_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      tmr_nx    = tmr;
      idx_nx    = idx;
      sh_nx     = sh;
      byte_good = 1'b0;
      byte_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (rs_d && !rs) begin
               tmr_nx   = HALF_LD;
               state_nx = START;
            end
         end
         START: begin
            if (!tick) begin
               tmr_nx = tmr - 1'b1;
            end else if (rs) begin
               state_nx = IDLE;
            end else begin
               tmr_nx   = BIT_LD;
               idx_nx   = 3'd0;
               state_nx = DATA;
            end
         end
         DATA: begin
            if (!tick) begin
               tmr_nx = tmr - 1'b1;
            end else begin
               sh_nx[idx] = rs;
               tmr_nx     = BIT_LD;
               idx_nx     = idx + 3'd1;
               if (idx == 3'd7) state_nx = STOP;
            end
         end
         STOP: begin
            if (!tick) begin
               tmr_nx = tmr - 1'b1;
            end else begin
               byte_good = rs;
               byte_bad  = !rs;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // full is raised one cycle after the wrapping write, hence full_pend.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_fifo_wd   <= '0;
         rx_fifo_wa   <= '0;
         rx_fifo_wen  <= 1'b0;
         rx_fifo_full <= 1'b0;
         framing_err  <= 1'b0;
         overrun      <= 1'b0;
         count        <= '0;
         tmo          <= '0;
         full_pend    <= 1'b0;
      end else begin
         rx_fifo_wen <= 1'b0;
         framing_err <= byte_bad;
         if (full_pend) begin
            rx_fifo_full <= 1'b1;
            full_pend    <= 1'b0;
         end
         if (rx_fifo_full && rx_fifo_full_ack) begin
            rx_fifo_full <= 1'b0;
            overrun      <= 1'b0;
         end else if (byte_good) begin
            if (rx_fifo_full) begin
               overrun <= 1'b1;
            end else begin
               rx_fifo_wen <= 1'b1;
               rx_fifo_wd  <= sh;
               rx_fifo_wa  <= count;
               tmo         <= '0;
               if (count == CNT_LAST) begin
                  count     <= '0;
                  full_pend <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
         end else if (count != '0 && !rx_fifo_full && !full_pend) begin
            // Partial frame abandoned by the sender: start the next frame at address 0.
            if (tmo == TMO_LAST) begin
               count <= '0;
               tmo   <= '0;
            end else begin
               tmo <= tmo + 1'b1;
            end
         end else begin
            tmo <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_loader.sv
// tb/tb_uart_rx_frame_loader.sv - randomized self-checking bench for uart_rx_frame_loader
// against a frame-level reference model.
module tb_uart_rx_frame_loader;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int TMO   = 50;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          rx = 1'b1;
   logic          ack = 1'b0;
   logic [7:0]    wd;
   logic [AW-1:0] wa;
   logic          wen, full, ferr, ovr;

   always #5 clk = ~clk;

   uart_rx_frame_loader #(
      .CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CLKS(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rx(rx), .rx_fifo_full_ack(ack),
      .rx_fifo_wd(wd), .rx_fifo_wa(wa), .rx_fifo_wen(wen),
      .rx_fifo_full(full), .framing_err(ferr), .overrun(ovr)
   );

   typedef struct packed {
      logic [7:0]    d;
      logic [AW-1:0] a;
      logic          wrap;
   } wr_t;

   wr_t    exp_q[$];
   int     n_chk = 0;
   int     n_pass = 0;
   int     ferr_seen = 0;
   int     m_ferr = 0;
   int     m_count = 0;
   bit     m_full = 0;
   bit     m_ovr = 0;
   longint cyc = 0;
   longint m_last = 0;
   bit     wrap_chk = 0;
   bit     ferr_prev = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Frame-level model: one call per correctly framed byte on the line.
   task automatic model_good(input logic [7:0] d);
      wr_t e;
      if (!m_full && m_count != 0 && (cyc - m_last) >= TMO) m_count = 0;
      if (m_full) begin
         m_ovr = 1;
      end else begin
         e.d    = d;
         e.a    = AW'(m_count);
         e.wrap = (m_count == DEPTH - 1);
         exp_q.push_back(e);
         m_last = cyc;
         m_count = (m_count + 1) % DEPTH;
         if (m_count == 0) m_full = 1;
      end
   endtask

   task automatic model_reset();
      m_count = 0;
      m_full  = 0;
      m_ovr   = 0;
      m_last  = cyc;
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] d, input bit stop_ok);
      logic [9:0] fr;
      fr = {stop_ok, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx = 1'b1;
      if (stop_ok) model_good(d);
      else m_ferr++;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_full"}, full, m_full);
      check_eq({tag, "_overrun"}, ovr, m_ovr);
      check_eq({tag, "_pending_writes"}, exp_q.size(), 0);
      check_eq({tag, "_ferr_pulses"}, ferr_seen, m_ferr);
   endtask

   task automatic pulse_ack(input string tag);
      ack = 1'b1;
      idle(1);
      ack = 1'b0;
      if (m_full) begin
         m_full = 0;
         m_ovr  = 0;
      end
      check_eq({tag, "_full"}, full, m_full);
      check_eq({tag, "_overrun"}, ovr, m_ovr);
      idle(1);
   endtask

   task automatic glitch(input int g);
      rx = 1'b0;
      idle(g);
      rx = 1'b1;
      idle(20);
   endtask

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            wrap_chk  = 0;
            ferr_prev = 0;
         end else begin
            if (wrap_chk) begin
               check_eq("full_1clk_after_wrap", full, 1);
               wrap_chk = 0;
            end
            if (wen) begin
               if (exp_q.size() == 0) begin
                  check_eq("unexpected_wen", wen, 0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("wd", wd, e.d);
                  check_eq("wa", wa, e.a);
                  check_eq("full_low_at_wen", full, 0);
                  wrap_chk = e.wrap;
               end
            end
            if (ferr) begin
               if (ferr_prev) check_eq("ferr_one_cycle", ferr_prev, 0);
               else ferr_seen++;
            end
            ferr_prev = ferr;
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int r;
      int gap;
      idle(3);
      check_eq("rst_wen", wen, 0);
      check_eq("rst_full", full, 0);
      check_eq("rst_ferr", ferr, 0);
      check_eq("rst_overrun", ovr, 0);
      check_eq("rst_wd", wd, 0);
      check_eq("rst_wa", wa, 0);
      reset_n = 1'b1;
      model_reset();
      idle(3);

      send_byte(8'hA5, 1);
      idle(4);
      check_state("a5");

      idle(60);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1);
      idle(4);
      check_state("frame4");

      send_byte(8'h55, 1);
      idle(4);
      check_state("overrun55");
      pulse_ack("ack1");
      send_byte(8'h66, 1);
      idle(4);
      check_state("b66");
      pulse_ack("ack_ignored");

      send_byte(8'h3C, 0);
      idle(4);
      check_state("ferr3c");

      glitch(2);
      check_state("glitch2");
      glitch(1);
      check_state("glitch1");

      send_byte(8'($urandom), 1);
      idle(4);
      send_byte(8'($urandom), 1);
      idle(60);
      send_byte(8'h77, 1);
      idle(4);
      check_state("timeout77");

      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 5 || (r == 9 && !m_full)) begin
            gap = $urandom_range(0, 2);
            send_byte(8'($urandom), 1);
            idle(4);
            repeat (gap) idle(1);
            check_state("rnd_byte");
         end else if (r == 6) begin
            send_byte(8'($urandom), 0);
            idle(4);
            check_state("rnd_ferr");
         end else if (r == 7) begin
            glitch($urandom_range(1, 2));
            check_state("rnd_glitch");
         end else if (r == 8) begin
            idle($urandom_range(60, 90));
            check_state("rnd_idle");
         end else begin
            pulse_ack("rnd_ack");
         end
      end

      while (!m_full) begin
         send_byte(8'($urandom), 1);
         idle(4);
      end
      send_byte(8'h99, 1);
      idle(4);
      check_state("pre_reset");
      rx = 1'b0;
      idle(CPB + 8);
      reset_n = 1'b0;
      #1;
      check_eq("midrst_wen", wen, 0);
      check_eq("midrst_full", full, 0);
      check_eq("midrst_ferr", ferr, 0);
      check_eq("midrst_overrun", ovr, 0);
      check_eq("midrst_wd", wd, 0);
      check_eq("midrst_wa", wa, 0);
      rx = 1'b1;
      model_reset();
      idle(3);
      reset_n = 1'b1;
      idle(3);
      send_byte(8'hC3, 1);
      idle(4);
      check_state("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
